// File: rtl/serial_add_seq.sv
// Nibble-serial adder/subtractor: one 4-bit slice per clock, LSB first.
// The result, carry and overflow are registered and only update on DONE.
module serial_add_seq #(
    parameter int NIBBLES = 4,
    parameter int W       = 4 * NIBBLES
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         START,
    input  logic         SUB,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] SUM,
    output logic         COUT,
    output logic         OVF
);
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_res;

    logic [3:0]    w_sa;
    logic [3:0]    w_sb;
    logic [4:0]    w_slice;
    logic [3:0]    w_lo3;
    logic [W-1:0]  w_full;
    logic [CW+1:0] w_base;

    assign w_base  = {r_cnt, 2'b00};
    assign w_sa    = r_a[w_base +: 4];
    assign w_sb    = r_b[w_base +: 4];
    assign w_slice = {1'b0, w_sa} + {1'b0, w_sb} + {4'b0, r_carry};
    // Carry into the slice MSB; on the last slice this is the carry into bit W-1.
    assign w_lo3   = {1'b0, w_sa[2:0]} + {1'b0, w_sb[2:0]} + {3'b0, r_carry};

    always_comb begin
        w_full = r_res;
        w_full[w_base +: 4] = w_slice[3:0];
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            SUM     <= '0;
            COUT    <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_a     <= A;
                        r_b     <= B ^ {W{SUB}};
                        r_carry <= SUB;
                        r_cnt   <= '0;
                        r_state <= RUN;
                        BUSY    <= 1'b1;
                    end
                end
                RUN: begin
                    r_res   <= w_full;
                    r_carry <= w_slice[4];
                    if (r_cnt == LAST) begin
                        SUM     <= w_full;
                        COUT    <= w_slice[4];
                        OVF     <= w_lo3[3] ^ w_slice[4];
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq with hand-computed 16-bit results.
module tb_serial_add_seq;
    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        START = 1'b0;
    logic        SUB = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        BUSY, DONE, COUT, OVF;
    logic [15:0] SUM;

    int checks = 0;
    int failures = 0;

    serial_add_seq #(.NIBBLES(4)) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .SUB(SUB), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .COUT(COUT), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Presents a request before the edge, then scrambles inputs after it.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
        @(negedge CLK);
        A = a; B = b; SUB = s; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; A = ~a; B = ~b; SUB = ~s;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!DONE && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [15:0] esum, input logic ec, input logic eo);
        int n;
        launch(a, b, s);
        wait_done(n);
        chk({tag, "_lat"}, n, 4);
        chk({tag, "_sum"}, SUM, esum);
        chk({tag, "_cout"}, COUT, ec);
        chk({tag, "_ovf"}, OVF, eo);
    endtask

    initial begin
        int n;
        int seen;
        #1;
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_sum", SUM, 0);
        chk("rst_flags", {COUT, OVF}, 0);
        @(negedge CLK); RSTN = 1'b1;

        // Basic add with BUSY/DONE timing.
        launch(16'h1234, 16'h0FFF, 1'b0);
        chk("busy_e0", BUSY, 1);
        repeat (3) begin @(posedge CLK); #1; end
        chk("busy_e3", BUSY, 1);
        chk("done_e3", DONE, 0);
        chk("sum_hidden_e3", SUM, 16'h0000);
        @(posedge CLK); #1;
        chk("done_e4", DONE, 1);
        chk("busy_e4", BUSY, 0);
        chk("add1_sum", SUM, 16'h2233);
        chk("add1_flags", {COUT, OVF}, 2'b00);
        @(posedge CLK); #1;
        chk("done_pulse", DONE, 0);
        chk("sum_hold", SUM, 16'h2233);

        run_op("wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("ovfp",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub1",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub2",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub0",  16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op("mix",   16'hA5C3, 16'h5A3D, 1'b0, 16'h0000, 1'b1, 1'b0);

        // START while busy is ignored; START in the DONE cycle is accepted.
        launch(16'h0001, 16'h0001, 1'b0);
        @(posedge CLK); #1;
        @(negedge CLK);
        A = 16'hAAAA; B = 16'h5555; SUB = 1'b1; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        wait_done(n);
        chk("ign_lat", n, 2);
        chk("ign_sum", SUM, 16'h0002);
        A = 16'h0003; B = 16'h0004; SUB = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; A = '0; B = '0;
        chk("b2b_busy", BUSY, 1);
        wait_done(n);
        chk("b2b_lat", n + 1, 5);
        chk("b2b_sum", SUM, 16'h0007);

        // Reset mid-run aborts without DONE.
        launch(16'h1111, 16'h2222, 1'b0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RSTN = 1'b0; #1;
        chk("arst_sum", SUM, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_done", DONE, 0);
        @(negedge CLK); @(negedge CLK); RSTN = 1'b1;
        seen = 0;
        repeat (6) begin @(posedge CLK); #1; if (DONE) seen++; end
        chk("arst_nodone", seen, 0);
        chk("arst_sum_hold", SUM, 0);
        run_op("post", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: RSTN  input  1  reset; asynchronous and active-low.
REQ-004 Port: START  input  1  request; sampled on rising CLK; accepted only when BUSY=0.
REQ-005 Port: SUB  input  1  operation select: 0 = A+B, 1 = A-B; sampled with START.
REQ-006 Port: A  input  W  operand A; sampled with START.
REQ-007 Port: B  input  W  operand B; sampled with START.
REQ-008 Port: BUSY  output  1  high while a request is in progress.
REQ-009 Port: DONE  output  1  single-cycle pulse marking valid SUM/COUT/OVF.
REQ-010 Port: SUM  output  W  registered result.
REQ-011 Port: COUT  output  1  carry out of MSB slice; for SUB=1, 1 means no borrow (A>=B unsigned).
REQ-012 Port: OVF  output  1  two's-complement overflow flag.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-014 In IDLE with START=1 at edge E0, the block SHALL latch A, B XOR {W{SUB}}, and carry = SUB, clear the slice counter to 0, and enter RUN.
REQ-015 BUSY SHALL equal 1 exactly while the state is RUN.
REQ-016 In RUN, each edge SHALL add slice i of the latched operands plus the carry register, store the 4-bit result into slice i of an internal result register, update the carry register, and increment the counter.
REQ-017 Slice 0 SHALL be processed at edge E1 and slice i at edge E(i+1), so processing runs LSB-first.
REQ-018 At edge E(NIBBLES), the block SHALL load SUM, COUT and OVF from the completed result, assert DONE for exactly one cycle, and return to IDLE.
REQ-019 OVF SHALL equal the carry into bit W-1 XOR the carry out of bit W-1.
REQ-020 SUM, COUT and OVF SHALL hold their values from DONE until the next DONE; partial results are never visible on the outputs.
REQ-021 START SHALL be ignored while BUSY=1, with no effect on the operation in progress or on the latched operands.
REQ-022 START SHALL be accepted in the cycle where DONE=1, because the state is IDLE; back-to-back throughput is one result per NIBBLES+1 cycles.
REQ-023 Changes on A, B or SUB after the START edge SHALL NOT affect the result.
REQ-024 The counter SHALL be ceil(log2(NIBBLES)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-025 While RSTN=0, asynchronously: state=IDLE, BUSY=0, DONE=0, SUM=0, COUT=0, OVF=0, counter=0, carry=0, operand and result registers=0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no DONE pulse; the first START after RSTN rises is accepted normally.

Verification
REQ-027 A=0x1234, B=0x0FFF, SUB=0, START at E0 -> BUSY high E0..E4; DONE pulse after E4; SUM=0x2233, COUT=0, OVF=0.
REQ-028 A=0xFFFF, B=0x0001, SUB=0 -> SUM=0x0000, COUT=1, OVF=0.
REQ-029 A=0x7FFF, B=0x0001, SUB=0 -> SUM=0x8000, COUT=0, OVF=1.
REQ-030 A=0x0005, B=0x0007, SUB=1 -> SUM=0xFFFE, COUT=0, OVF=0; then A=0x8000, B=0x0001, SUB=1 -> SUM=0x7FFF, COUT=1, OVF=1.
REQ-031 START with A=0x0001, B=0x0001, then START at E2 with A=0xAAAA -> the second START is ignored and SUM=0x0002; a START in the DONE cycle is accepted and its DONE follows 5 cycles later.
REQ-032 RSTN pulsed low at E2 of an operation -> outputs clear immediately and no DONE occurs; a new START after release yields the correct result.
